flit_injector: RTL and testbench
================================

Name: flit_injector

Overview:
Per-input-port packet transmitter that feeds the router's 5-port arbiter.
- Accepts a packet descriptor and a payload word stream from the local core or network interface.
- Drives the arbiter request interface for one port: req, flit_id and length.
- Serializes header, body and tail flits only while this port's grant bit is set.
- One instance per port (L, N, E, W, S); grant is that port's bit of the arbiter's one-hot state.

Parameters:
DATA_W, 32, flit/payload width (>= 15)
TIMEOUT_SLACK, 4, extra clock periods added to the packet length for the arbiter timeout
MIN_LEN, 2, minimum flits per packet (header + tail)

Ports:
clk  in  1  clock
rst  in  1  asynchronous, active-low reset
pkt_valid  in  1  descriptor valid
pkt_ready  out  1  descriptor accepted when pkt_valid & pkt_ready
pkt_len  in  12  total flits including header and tail
pkt_dest  in  3  destination port code, carried in the header
data_valid  in  1  payload word valid
data_ready  out  1  payload word consumed when data_valid & data_ready
data_in  in  DATA_W  payload word
grant  in  1  arbiter currently serving this port
req  out  1  request to arbiter
flit_id  out  3  3'b001 header, 3'b010 body, 3'b100 tail, 3'b000 idle
length  out  12  timeout in clock periods, sampled by the arbiter timer when flit_id == 3'b001
flit_valid  out  1  flit_out holds a valid flit
flit_out  out  DATA_W  flit payload

Behaviour:
- Reset (rst low, async):
  - State IDLE; req, flit_valid, flit_id, length and flit_out all 0; stats counters 0.
  - Any in-flight packet is dropped; no partial tail is sent.
- Transfer definition: a flit moves in any cycle with req & grant & flit_valid.
- States: IDLE, HEAD, BODY, TAIL.
- IDLE:
  - pkt_ready = 1; data_ready = 0.
  - On pkt_valid, capture eff_len = max(pkt_len, MIN_LEN) and go to HEAD.
- HEAD:
  - Starts one cycle after descriptor acceptance.
  - Outputs: req = 1, flit_id = 001, flit_valid = 1.
  - flit_out = {zero pad, pkt_dest, eff_len}.
  - length = min(eff_len + TIMEOUT_SLACK, 4095), computed 13-bit then saturated.
  - Held stable until transfer.
  - After transfer: go to BODY with rem = eff_len - 2 if eff_len > 2; otherwise go to TAIL.
- BODY/TAIL output register:
  - data_ready = !flit_valid | transfer.
  - On a data handshake, load flit_out = data_in and set flit_valid = 1.
  - flit_id = 010 in BODY, 100 in TAIL.
  - Without a handshake, a transfer clears flit_valid (bubble). req stays 1 throughout the bubble.
- BODY counting: each body transfer decrements rem; the transfer that takes rem to 0 moves the state to TAIL.
- TAIL: on transfer go to IDLE; req drops the next cycle.
  - Minimum of one IDLE cycle between packets.
- Payload accounting: payload words consumed per packet = eff_len - 1.
- Grant loss mid-packet (arbiter timeout or preemption):
  - Hold state, flit and req; no header retransmit.
  - Resume on re-grant.
- length is held constant from HEAD through TAIL; it is 0 in IDLE.
- grant while req = 0 is ignored.

Optional Feature:
FLIT_INJECTOR_STATS_EN
- Defined: adds outputs pkt_count[15:0] and stall_count[15:0], both wrapping.
  - pkt_count increments on each tail transfer.
  - stall_count increments on each cycle with req & !grant.
- Undefined: no such ports and no stats logic.

Decomposition:
- Shared package noc_pkg holds:
  - flit_id constants FLIT_IDLE, FLIT_HEAD, FLIT_BODY, FLIT_TAIL;
  - port codes L = 0, N = 1, E = 2, W = 3, S = 4;
  - the 12-bit length type.
- One natural sub-module: flit_out_reg (single-entry skid/output register with valid/ready).

Test Plan:
- Reset: assert rst low mid-BODY -> outputs 0 immediately; after release, pkt_ready = 1 and the next packet starts with a header.
- pkt_len = 4, grant held 1 -> flit_id sequence 001, 010, 010, 100 on consecutive cycles; length = 8; 3 data words consumed; req low the cycle after the tail.
- pkt_len = 5, grant drops for 3 cycles after the first body -> flit held stable, req = 1 throughout; resumes with the second body; no duplicate header.
- pkt_len = 1 -> clamped to 2: header then tail, 1 data word, header field shows length 2.
- pkt_len = 4094 -> length = 4095 (saturated); data_valid gap of 2 cycles -> flit_valid bubble, req stays 1.
- With FLIT_INJECTOR_STATS_EN: two packets plus 3 ungranted cycles -> pkt_count = 2, stall_count = 3.

Source files
------------

// File: rtl/noc_pkg.sv
// Shared NoC definitions: flit_id codes, port codes, length type and injector states.
package noc_pkg;

  localparam logic [2:0] FLIT_IDLE = 3'b000;
  localparam logic [2:0] FLIT_HEAD = 3'b001;
  localparam logic [2:0] FLIT_BODY = 3'b010;
  localparam logic [2:0] FLIT_TAIL = 3'b100;

  typedef enum logic [2:0] {
    PORT_L = 3'd0,
    PORT_N = 3'd1,
    PORT_E = 3'd2,
    PORT_W = 3'd3,
    PORT_S = 3'd4
  } port_e;

  typedef logic [11:0] len_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_HEAD,
    ST_BODY,
    ST_TAIL
  } inj_state_e;

  // Arbiter timeout: add slack in 13 bits, then clamp to the 12-bit range.
  function automatic len_t sat_len(len_t len, int slack);
    logic [12:0] sum;
    sum = {1'b0, len} + 13'(slack);
    return sum[12] ? 12'hFFF : sum[11:0];
  endfunction

endpackage

// File: rtl/flit_injector_if.sv
// Descriptor, payload and arbiter-request signals of one flit_injector port.
interface flit_injector_if
  import noc_pkg::*;
#(
  parameter int DATA_W = 32
);
  logic              pkt_valid;
  logic              pkt_ready;
  len_t              pkt_len;
  logic [2:0]        pkt_dest;
  logic              data_valid;
  logic              data_ready;
  logic [DATA_W-1:0] data_in;
  logic              grant;
  logic              req;
  logic [2:0]        flit_id;
  len_t              length;
  logic              flit_valid;
  logic [DATA_W-1:0] flit_out;

  modport master (
    input  pkt_valid, pkt_len, pkt_dest, data_valid, data_in, grant,
    output pkt_ready, data_ready, req, flit_id, length, flit_valid, flit_out
  );

  modport slave (
    output pkt_valid, pkt_len, pkt_dest, data_valid, data_in, grant,
    input  pkt_ready, data_ready, req, flit_id, length, flit_valid, flit_out
  );
endinterface

// File: rtl/flit_injector_out_reg.sv
// flit_out_reg: single-entry output register holding the next body/tail payload word.
module flit_out_reg #(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              fill_en,
  input  logic              pass_en,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic              out_ready,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data
);

  // pass_en allows refill in the same cycle the held word leaves.
  assign in_ready = fill_en & (~out_valid | (pass_en & out_ready));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
    end else if (in_valid && in_ready) begin
      out_valid <= 1'b1;
      out_data  <= in_data;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/flit_injector.sv
// flit_injector: serializes header/body/tail flits toward one arbiter port.
// Optional stats counters enabled by FLIT_INJECTOR_STATS_EN.
//
// state | meaning
// IDLE  | waiting for a descriptor, pkt_ready high
// HEAD  | presenting header flit, prefetching first payload word
// BODY  | presenting body flits, rem counts bodies still to send
// TAIL  | presenting tail flit, back to IDLE on transfer
module flit_injector
  import noc_pkg::*;
#(
  parameter int DATA_W        = 32,
  parameter int TIMEOUT_SLACK = 4,
  parameter int MIN_LEN       = 2
) (
  input  logic clk,
  input  logic rst,
  flit_injector_if.master bus
`ifdef FLIT_INJECTOR_STATS_EN
  ,
  output logic [15:0] pkt_count,
  output logic [15:0] stall_count
`endif
);

  inj_state_e        state, state_nxt;
  len_t              eff_len_q, len_q, rem_q, pkt_eff;
  logic [2:0]        dest_q;
  logic              accept, xfer, in_frame;
  logic              reg_in_ready, reg_valid, reg_pop;
  logic [DATA_W-1:0] reg_data, hdr;
  logic              req_c, fv_c, pkt_ready_c;
  logic [2:0]        id_c;
  logic [DATA_W-1:0] out_c;

  assign pkt_eff  = (bus.pkt_len < len_t'(MIN_LEN)) ? len_t'(MIN_LEN) : bus.pkt_len;
  assign accept   = (state == ST_IDLE) & bus.pkt_valid;
  assign in_frame = (state == ST_BODY) | (state == ST_TAIL);
  assign xfer     = bus.grant & ((state == ST_HEAD) | (in_frame & reg_valid));
  assign reg_pop  = xfer & in_frame;

  always_comb begin
    hdr       = '0;
    hdr[14:0] = {dest_q, eff_len_q};
  end

  flit_out_reg #(.DATA_W(DATA_W)) u_out_reg (
    .clk       (clk),
    .rst       (rst),
    .fill_en   (state != ST_IDLE),
    .pass_en   (state == ST_BODY),
    .in_valid  (bus.data_valid),
    .in_ready  (reg_in_ready),
    .in_data   (bus.data_in),
    .out_ready (reg_pop),
    .out_valid (reg_valid),
    .out_data  (reg_data)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= ST_IDLE;
    else      state <= state_nxt;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      eff_len_q <= '0;
      len_q     <= '0;
      rem_q     <= '0;
      dest_q    <= '0;
    end else begin
      if (accept) begin
        eff_len_q <= pkt_eff;
        len_q     <= sat_len(pkt_eff, TIMEOUT_SLACK);
        dest_q    <= bus.pkt_dest;
      end
      if (state == ST_HEAD && xfer)      rem_q <= eff_len_q - 12'd2;
      else if (state == ST_BODY && xfer) rem_q <= rem_q - 12'd1;
    end
  end

  always_comb begin
    state_nxt   = state;
    req_c       = 1'b0;
    fv_c        = 1'b0;
    id_c        = FLIT_IDLE;
    out_c       = '0;
    pkt_ready_c = 1'b0;
    case (state)
      ST_IDLE: begin
        pkt_ready_c = 1'b1;
        if (bus.pkt_valid) state_nxt = ST_HEAD;
      end
      ST_HEAD: begin
        req_c = 1'b1;
        fv_c  = 1'b1;
        id_c  = FLIT_HEAD;
        out_c = hdr;
        if (xfer) state_nxt = (eff_len_q > 12'd2) ? ST_BODY : ST_TAIL;
      end
      ST_BODY: begin
        req_c = 1'b1;
        fv_c  = reg_valid;
        id_c  = FLIT_BODY;
        out_c = reg_data;
        if (xfer && rem_q == 12'd1) state_nxt = ST_TAIL;
      end
      ST_TAIL: begin
        req_c = 1'b1;
        fv_c  = reg_valid;
        id_c  = FLIT_TAIL;
        out_c = reg_data;
        if (xfer) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  assign bus.pkt_ready  = pkt_ready_c;
  assign bus.data_ready = reg_in_ready;
  assign bus.req        = req_c;
  assign bus.flit_id    = id_c;
  assign bus.flit_valid = fv_c;
  assign bus.flit_out   = out_c;
  assign bus.length     = (state == ST_IDLE) ? '0 : len_q;

`ifdef FLIT_INJECTOR_STATS_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pkt_count   <= '0;
      stall_count <= '0;
    end else begin
      if (state == ST_TAIL && xfer) pkt_count   <= pkt_count + 16'd1;
      if (req_c && !bus.grant)      stall_count <= stall_count + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_flit_injector.sv
// Scoreboard bench for flit_injector: expected flits queued at issue, checked by a monitor.
module tb_flit_injector;
  import noc_pkg::*;

  typedef struct {
    logic [2:0]  id;
    logic [31:0] data;
    logic [11:0] len;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   checks = 0;
  int   failures = 0;
  int   consumed = 0;
  int   gap = 0;
  exp_t sb[$];
  logic [31:0] dq[$];

  flit_injector_if #(.DATA_W(32)) bus ();

`ifdef FLIT_INJECTOR_STATS_EN
  logic [15:0] pkt_count, stall_count;
`endif

  flit_injector #(.DATA_W(32), .TIMEOUT_SLACK(4), .MIN_LEN(2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
`ifdef FLIT_INJECTOR_STATS_EN
    ,
    .pkt_count   (pkt_count),
    .stall_count (stall_count)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // Monitor: every transfer pops one expected flit.
  always @(negedge clk) begin
    if (rst && bus.req && bus.grant && bus.flit_valid) begin
      if (sb.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL sb_unexpected flit_id=%0h flit_out=%0h expected none", bus.flit_id, bus.flit_out);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("flit_id", bus.flit_id, e.id);
        chk("flit_out", bus.flit_out, e.data);
        chk("flit_length", bus.length, e.len);
      end
    end
  end

  // Payload feeder: presents dq words, counts handshakes, honours gap cycles.
  initial begin
    logic hs;
    bus.data_valid = 1'b0;
    bus.data_in    = '0;
    forever begin
      @(negedge clk);
      hs = bus.data_valid & bus.data_ready & rst;
      @(posedge clk);
      #1;
      if (hs && dq.size() > 0) begin
        void'(dq.pop_front());
        consumed++;
      end
      if (gap > 0) begin
        gap--;
        bus.data_valid = 1'b0;
      end else if (dq.size() > 0) begin
        bus.data_valid = 1'b1;
        bus.data_in    = dq[0];
      end else begin
        bus.data_valid = 1'b0;
      end
    end
  end

  // Queue expectations and payload, then hand over the descriptor; returns just after acceptance.
  task automatic send_pkt(input logic [11:0] len, input logic [2:0] dest, input logic [31:0] base);
    logic [11:0] eff;
    int          s, k;
    eff = (len < 12'd2) ? 12'd2 : len;
    s   = int'(eff) + 4;
    if (s > 4095) s = 4095;
    sb.push_back('{FLIT_HEAD, {17'd0, dest, eff}, 12'(s)});
    for (int i = 0; i < int'(eff) - 1; i++) begin
      dq.push_back(base + 32'(i));
      sb.push_back('{(i == int'(eff) - 2) ? FLIT_TAIL : FLIT_BODY, base + 32'(i), 12'(s)});
    end
    bus.pkt_len   = len;
    bus.pkt_dest  = dest;
    bus.pkt_valid = 1'b1;
    k = 0;
    while (!bus.pkt_ready && k < 100) begin
      @(negedge clk);
      k++;
    end
    chk("pkt_accept_timeout", k < 100, 1);
    @(posedge clk);
    #1;
    bus.pkt_valid = 1'b0;
  endtask

  task automatic wait_done(input int bound);
    int k;
    k = 0;
    while ((sb.size() != 0 || bus.req) && k < bound) begin
      @(negedge clk);
      k++;
    end
    chk("done_timeout", k < bound, 1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int bubbles;
    logic req_held;
    bus.pkt_valid = 1'b0;
    bus.pkt_len   = '0;
    bus.pkt_dest  = '0;
    bus.grant     = 1'b0;

    // Reset values
    repeat (2) @(negedge clk);
    chk("rst_req", bus.req, 0);
    chk("rst_flit_valid", bus.flit_valid, 0);
    chk("rst_flit_id", bus.flit_id, 0);
    chk("rst_length", bus.length, 0);
    chk("rst_flit_out", bus.flit_out, 0);
    chk("rst_pkt_ready", bus.pkt_ready, 1);
    chk("rst_data_ready", bus.data_ready, 0);
    rst = 1'b1;
    bus.grant = 1'b1;
    @(negedge clk);

    // Reset asserted mid-body
    send_pkt(12'd6, 3'd0, 32'hD000_0000);
    @(negedge clk);
    @(negedge clk);
    chk("mid_body_id", bus.flit_id, FLIT_BODY);
    rst = 1'b0;
    #1;
    chk("async_req", bus.req, 0);
    chk("async_flit_valid", bus.flit_valid, 0);
    chk("async_flit_id", bus.flit_id, 0);
    chk("async_length", bus.length, 0);
    chk("async_flit_out", bus.flit_out, 0);
    sb.delete();
    dq.delete();
    bus.data_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    #1;
    chk("post_rst_pkt_ready", bus.pkt_ready, 1);
    @(negedge clk);

    // pkt_len=4, grant held: consecutive 001,010,010,100
    consumed = 0;
    send_pkt(12'd4, 3'd2, 32'hA000_0000);
    @(negedge clk);
    chk("p4_head_id", bus.flit_id, FLIT_HEAD);
    chk("p4_length", bus.length, 8);
    @(negedge clk);
    chk("p4_body0_id", bus.flit_id, FLIT_BODY);
    chk("p4_body0_valid", bus.flit_valid, 1);
    @(negedge clk);
    chk("p4_body1_id", bus.flit_id, FLIT_BODY);
    chk("p4_body1_valid", bus.flit_valid, 1);
    @(negedge clk);
    chk("p4_tail_id", bus.flit_id, FLIT_TAIL);
    chk("p4_tail_valid", bus.flit_valid, 1);
    @(negedge clk);
    chk("p4_req_after_tail", bus.req, 0);
    chk("p4_length_idle", bus.length, 0);
    wait_done(100);
    chk("p4_words", consumed, 3);

    // pkt_len=5, grant drops for 3 cycles after the first body
    consumed = 0;
    send_pkt(12'd5, 3'd1, 32'hB000_0000);
    @(posedge clk);
    @(posedge clk);
    #1;
    bus.grant = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("stall_req", bus.req, 1);
      chk("stall_id", bus.flit_id, FLIT_BODY);
      chk("stall_valid", bus.flit_valid, 1);
      chk("stall_flit_out", bus.flit_out, 32'hB000_0001);
      chk("stall_length", bus.length, 9);
    end
    @(posedge clk);
    #1;
    bus.grant = 1'b1;
    wait_done(100);
    chk("p5_words", consumed, 4);
`ifdef FLIT_INJECTOR_STATS_EN
    chk("pkt_count", pkt_count, 2);
    chk("stall_count", stall_count, 3);
`endif

    // pkt_len=1 clamps to 2
    @(negedge clk);
    consumed = 0;
    send_pkt(12'd1, 3'd4, 32'hC000_0000);
    @(negedge clk);
    chk("p1_length", bus.length, 6);
    wait_done(100);
    chk("p1_words", consumed, 1);

    // pkt_len=4094: saturated length, payload gap gives a bubble with req held
    @(negedge clk);
    consumed = 0;
    send_pkt(12'd4094, 3'd3, 32'h0001_0000);
    @(negedge clk);
    chk("big_length", bus.length, 4095);
    repeat (20) @(negedge clk);
    gap = 2;
    bubbles  = 0;
    req_held = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (!bus.flit_valid) bubbles++;
      if (!bus.req) req_held = 1'b0;
    end
    chk("bubble_cycles", bubbles, 2);
    chk("bubble_req_held", req_held, 1);
    wait_done(10000);
    chk("big_words", consumed, 4093);

    chk("sb_drained", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
